// File: rtl/swerv_axi_arb_pkg.sv
// swerv_axi_arb_pkg
//   Shared definitions for the SweRV AXI read-channel arbiter:
//   requester index constants, the AR slice payload struct, the slice FSM
//   state enum and a mod-3 increment helper for the round-robin pointer.
//   Optional build macro used by the users of this package:
//     SWERV_AXI_ARB_LSU_PRIO_EN - LSU gets fixed top priority.
package swerv_axi_arb_pkg;

    localparam logic [1:0] IFU     = 2'd0;
    localparam logic [1:0] LSU     = 2'd1;
    localparam logic [1:0] SB      = 2'd2;
    localparam logic [1:0] BAD_IDX = 2'd3;   // no requester behind this index

    typedef enum logic {
        IDLE = 1'b0,   // AR slice empty
        HOLD = 1'b1    // AR slice full, m_arvalid high
    } arb_state_e;

    // Requester-independent part of the registered AR; the requester's
    // own ID is held beside it because its width is a module parameter.
    typedef struct packed {
        logic [1:0]  idx;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
    } ar_slice_t;

    function automatic logic [1:0] rr_inc(input logic [1:0] i);
        return (i >= SB) ? IFU : i + 2'd1;
    endfunction

endpackage

// File: rtl/swerv_rr_arb3.sv
// swerv_rr_arb3
//   Three-way arbiter with the pointer register kept inside.
//   Default build: round-robin, search starts at the pointer, pointer moves
//   to (winner+1) mod 3 after each grant.
//   SWERV_AXI_ARB_LSU_PRIO_EN defined: LSU always wins when it requests;
//   IFU and SB round-robin between themselves, and an LSU grant leaves
//   their pointer untouched.
// Ports:
//   clk, rst_l - clock, async active-low reset
//   req        - per-requester request (AR valid)
//   elig       - per-requester eligibility (below outstanding limit)
//   en         - the AR slice can accept a new entry this cycle
//   gnt        - one-hot grant, zero when nothing is granted
module swerv_rr_arb3
    import swerv_axi_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_l,
    input  logic [2:0] req,
    input  logic [2:0] elig,
    input  logic       en,
    output logic [2:0] gnt
);

    logic [1:0] ptr_q;
    logic [1:0] win;
    logic       found;
    logic [2:0] cand;

`ifdef SWERV_AXI_ARB_LSU_PRIO_EN
    logic [1:0] other;

    always_comb begin
        cand  = req & elig & {3{en}};
        other = (ptr_q == IFU) ? SB : IFU;
        found = 1'b0;
        win   = ptr_q;
        if (cand[LSU]) begin
            found = 1'b1;
            win   = LSU;
        end else if (cand[ptr_q]) begin
            found = 1'b1;
            win   = ptr_q;
        end else if (cand[other]) begin
            found = 1'b1;
            win   = other;
        end
        gnt = found ? (3'b001 << win) : 3'b000;
    end

    // Pointer only ever holds IFU or SB in this mode.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l)                    ptr_q <= IFU;
        else if (found && win != LSU)  ptr_q <= (win == IFU) ? SB : IFU;
    end
`else
    logic [1:0] idx;

    always_comb begin
        cand  = req & elig & {3{en}};
        found = 1'b0;
        win   = ptr_q;
        idx   = ptr_q;
        for (int k = 0; k < 3; k++) begin
            if (!found && cand[idx]) begin
                found = 1'b1;
                win   = idx;
            end
            idx = rr_inc(idx);
        end
        gnt = found ? (3'b001 << win) : 3'b000;
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l)      ptr_q <= IFU;
        else if (found)  ptr_q <= rr_inc(win);
    end
`endif

endmodule

// File: rtl/swerv_axi_rd_arb.sv
// swerv_axi_rd_arb
//   Merges the AXI read channels of IFU (0), LSU (1) and SB (2) onto one
//   downstream port. AR: arbitrated into a one-entry output slice
//   (m_arvalid one cycle after grant), m_arid = {requester idx, s_arid}.
//   R: steered back combinationally by the top two bits of m_rid; index 3
//   is drained (m_rready=1) and flags the sticky rid_err.
//   Each requester is limited to MAX_OUTST outstanding bursts.
//   Build macro: SWERV_AXI_ARB_LSU_PRIO_EN (see swerv_rr_arb3).
// Ports:
//   clk, rst_l                         - clock, async active-low reset
//   s_ar{valid,ready,id,addr,len,size} - per-requester AR, flattened x3
//   s_r{valid,last,ready}              - per-requester R handshake
//   s_r{id,data,resp}                  - shared R payload
//   m_ar*, m_r*                        - downstream AR / R channels
//   rid_err                            - sticky illegal-R-index flag
module swerv_axi_rd_arb
    import swerv_axi_arb_pkg::*;
#(
    parameter int TAG_W     = 3,
    parameter int MAX_OUTST = 4
) (
    input  logic                 clk,
    input  logic                 rst_l,
    input  logic [2:0]           s_arvalid,
    output logic [2:0]           s_arready,
    input  logic [3*TAG_W-1:0]   s_arid,
    input  logic [3*32-1:0]      s_araddr,
    input  logic [3*8-1:0]       s_arlen,
    input  logic [3*3-1:0]       s_arsize,
    output logic [2:0]           s_rvalid,
    output logic [2:0]           s_rlast,
    input  logic [2:0]           s_rready,
    output logic [TAG_W-1:0]     s_rid,
    output logic [63:0]          s_rdata,
    output logic [1:0]           s_rresp,
    output logic                 m_arvalid,
    input  logic                 m_arready,
    output logic [TAG_W+1:0]     m_arid,
    output logic [31:0]          m_araddr,
    output logic [7:0]           m_arlen,
    output logic [2:0]           m_arsize,
    input  logic                 m_rvalid,
    output logic                 m_rready,
    input  logic [TAG_W+1:0]     m_rid,
    input  logic [63:0]          m_rdata,
    input  logic [1:0]           m_rresp,
    input  logic                 m_rlast,
    output logic                 rid_err
);

    localparam int              CNT_W   = 4;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTST);

    arb_state_e              state_q, state_d;
    logic                    slice_free;
    logic [2:0]              gnt, elig, dec;
    logic                    any_gnt;
    ar_slice_t               slice_q, slice_d;
    logic [TAG_W-1:0]        sid_q, sid_d;
    logic [2:0][CNT_W-1:0]   cnt_q;
    logic [1:0]              ridx;
    logic [2:0]              rsel;
    logic                    rid_err_q;

    // ---------------- AR arbitration ----------------
    always_comb begin
        for (int i = 0; i < 3; i++) elig[i] = (cnt_q[i] < MAX_CNT);
    end

    // rst_l gating keeps s_arready low while reset is held, even though
    // the slice looks free in IDLE.
    swerv_rr_arb3 u_arb (
        .clk   (clk),
        .rst_l (rst_l),
        .req   (s_arvalid),
        .elig  (elig),
        .en    (slice_free & rst_l),
        .gnt   (gnt)
    );

    assign s_arready = gnt;
    assign any_gnt   = |gnt;

    // ---------------- slice FSM ----------------
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_gnt) state_d = HOLD;
            HOLD:    if (m_arready && !any_gnt) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Slice can take a new entry when empty or when drained this cycle.
    always_comb begin
        m_arvalid  = (state_q == HOLD);
        slice_free = (state_q == IDLE) || m_arready;
    end

    // ---------------- AR slice payload ----------------
    always_comb begin
        slice_d = slice_q;
        sid_d   = sid_q;
        for (int i = 0; i < 3; i++) begin
            if (gnt[i]) begin
                slice_d.idx  = 2'(i);
                slice_d.addr = s_araddr[i*32 +: 32];
                slice_d.len  = s_arlen[i*8 +: 8];
                slice_d.size = s_arsize[i*3 +: 3];
                sid_d        = s_arid[i*TAG_W +: TAG_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            slice_q <= '0;
            sid_q   <= '0;
        end else if (any_gnt) begin
            slice_q <= slice_d;
            sid_q   <= sid_d;
        end
    end

    assign m_arid   = {slice_q.idx, sid_q};
    assign m_araddr = slice_q.addr;
    assign m_arlen  = slice_q.len;
    assign m_arsize = slice_q.size;

    // ---------------- R routing ----------------
    assign ridx     = m_rid[TAG_W+1:TAG_W];
    assign rsel     = (ridx == BAD_IDX) ? 3'b000 : (3'b001 << ridx);
    assign s_rvalid = rsel & {3{m_rvalid}};
    assign s_rlast  = rsel & {3{m_rlast}};
    assign m_rready = (ridx == BAD_IDX) || (|(rsel & s_rready));
    assign s_rid    = m_rid[TAG_W-1:0];
    assign s_rdata  = m_rdata;
    assign s_rresp  = m_rresp;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l)                              rid_err_q <= 1'b0;
        else if (m_rvalid && ridx == BAD_IDX)    rid_err_q <= 1'b1;
    end
    assign rid_err = rid_err_q;

    // ---------------- outstanding counters ----------------
    assign dec = s_rvalid & s_rready & {3{m_rlast}};

    // Simultaneous AR grant and last-beat return cancel out; the guards
    // keep the counter from wrapping in either direction.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (gnt[i] && !dec[i] && cnt_q[i] < MAX_CNT)
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                else if (dec[i] && !gnt[i] && cnt_q[i] != '0)
                    cnt_q[i] <= cnt_q[i] - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_swerv_axi_rd_arb.sv
// tb_swerv_axi_rd_arb
//   Self-checking bench: AR handshakes on the requester side push the
//   expected downstream AR into a queue, downstream AR handshakes pop and
//   compare it; directed checks cover grant order, outstanding limit,
//   backpressure, R routing, illegal index and counter cancellation.
module tb_swerv_axi_rd_arb;

    localparam int TAG_W = 3;

    typedef struct {
        logic [TAG_W+1:0] id;
        logic [31:0]      addr;
        logic [7:0]       len;
        logic [2:0]       size;
    } ar_exp_t;

    logic                 clk = 1'b0;
    logic                 rst_l = 1'b0;
    logic [2:0]           s_arvalid = '0;
    logic [2:0]           s_arready;
    logic [3*TAG_W-1:0]   s_arid = '0;
    logic [3*32-1:0]      s_araddr = '0;
    logic [3*8-1:0]       s_arlen = '0;
    logic [3*3-1:0]       s_arsize = '0;
    logic [2:0]           s_rvalid, s_rlast;
    logic [2:0]           s_rready = '0;
    logic [TAG_W-1:0]     s_rid;
    logic [63:0]          s_rdata;
    logic [1:0]           s_rresp;
    logic                 m_arvalid;
    logic                 m_arready = 1'b0;
    logic [TAG_W+1:0]     m_arid;
    logic [31:0]          m_araddr;
    logic [7:0]           m_arlen;
    logic [2:0]           m_arsize;
    logic                 m_rvalid = 1'b0;
    logic                 m_rready;
    logic [TAG_W+1:0]     m_rid = '0;
    logic [63:0]          m_rdata = '0;
    logic [1:0]           m_rresp = '0;
    logic                 m_rlast = 1'b0;
    logic                 rid_err;

    int n_chk  = 0;
    int n_fail = 0;
    ar_exp_t sb_q[$];

    always #5 clk = ~clk;

    swerv_axi_rd_arb #(.TAG_W(TAG_W), .MAX_OUTST(4)) dut (
        .clk       (clk),
        .rst_l     (rst_l),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_arid    (s_arid),
        .s_araddr  (s_araddr),
        .s_arlen   (s_arlen),
        .s_arsize  (s_arsize),
        .s_rvalid  (s_rvalid),
        .s_rlast   (s_rlast),
        .s_rready  (s_rready),
        .s_rid     (s_rid),
        .s_rdata   (s_rdata),
        .s_rresp   (s_rresp),
        .m_arvalid (m_arvalid),
        .m_arready (m_arready),
        .m_arid    (m_arid),
        .m_araddr  (m_araddr),
        .m_arlen   (m_arlen),
        .m_arsize  (m_arsize),
        .m_rvalid  (m_rvalid),
        .m_rready  (m_rready),
        .m_rid     (m_rid),
        .m_rdata   (m_rdata),
        .m_rresp   (m_rresp),
        .m_rlast   (m_rlast),
        .rid_err   (rid_err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: pop/compare on downstream handshake, push on requester
    // handshake (an entry can never appear downstream in its grant cycle).
    always @(negedge clk) begin
        if (rst_l) begin
            if (m_arvalid && m_arready) begin
                chk("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
                if (sb_q.size() != 0) begin
                    ar_exp_t e;
                    e = sb_q.pop_front();
                    chk("sb_arid",   64'(m_arid),   64'(e.id));
                    chk("sb_araddr", 64'(m_araddr), 64'(e.addr));
                    chk("sb_arlen",  64'(m_arlen),  64'(e.len));
                    chk("sb_arsize", 64'(m_arsize), 64'(e.size));
                end
            end
            for (int i = 0; i < 3; i++) begin
                if (s_arvalid[i] && s_arready[i]) begin
                    ar_exp_t e;
                    e.id   = {2'(i), s_arid[i*TAG_W +: TAG_W]};
                    e.addr = s_araddr[i*32 +: 32];
                    e.len  = s_arlen[i*8 +: 8];
                    e.size = s_arsize[i*3 +: 3];
                    sb_q.push_back(e);
                end
            end
        end
    end

    task automatic do_reset(input logic [2:0] arv);
        @(posedge clk); #1;
        rst_l     = 1'b0;
        s_arvalid = arv;
        m_arready = 1'b0;
        m_rvalid  = 1'b0;
        m_rlast   = 1'b0;
        s_rready  = '0;
        sb_q.delete();
        @(negedge clk);
        chk("rst_m_arvalid", 64'(m_arvalid), 64'd0);
        chk("rst_s_arready", 64'(s_arready), 64'd0);
        chk("rst_rid_err",   64'(rid_err),   64'd0);
        @(posedge clk); #1;
        rst_l = 1'b1;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    initial begin
        logic [1:0] exp_ord [4];
        exp_ord = '{2'd0, 2'd1, 2'd2, 2'd0};
        for (int i = 0; i < 3; i++) begin
            s_arid[i*TAG_W +: TAG_W] = 3'(i + 1);
            s_araddr[i*32 +: 32]     = 32'h1000_0000 + 32'(i) * 32'h100;
            s_arlen[i*8 +: 8]        = 8'(i + 3);
            s_arsize[i*3 +: 3]       = 3'(i + 1);
        end

        // Three-way round-robin from reset, continuous requests.
        do_reset(3'b111);
        m_arready = 1'b1;
        @(negedge clk);
        chk("rr_first_gnt", 64'(s_arready), 64'b001);
        chk("rr_lat_vld0",  64'(m_arvalid), 64'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rr_m_arvalid", 64'(m_arvalid), 64'd1);
            chk("rr_order",     64'(m_arid[TAG_W+1:TAG_W]), 64'(exp_ord[k]));
        end

        // Outstanding limit on LSU, IFU still served.
        do_reset(3'b000);
        m_arready = 1'b1;
        s_arvalid = 3'b010;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("lim_lsu_gnt", 64'(s_arready), 64'b010);
            step();
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("lim_lsu_block", 64'(s_arready), 64'b000);
            step();
        end
        s_arvalid = 3'b011;
        @(negedge clk);
        chk("lim_ifu_gnt", 64'(s_arready), 64'b001);
        step();
        s_arvalid = 3'b010;
        @(negedge clk);
        chk("lim_lsu_still", 64'(s_arready), 64'b000);

        // Counter: one LSU last beat, then AR + last beat in the same cycle.
        step();
        s_arvalid = 3'b000;
        m_rvalid  = 1'b1;
        m_rid     = {2'd1, 3'd2};
        m_rlast   = 1'b1;
        s_rready  = 3'b010;
        @(negedge clk);
        chk("cnt_rvalid", 64'(s_rvalid), 64'b010);
        chk("cnt_rready", 64'(m_rready), 64'd1);
        step();
        s_arvalid = 3'b010;
        @(negedge clk);
        chk("cnt_same_ar", 64'(s_arready), 64'b010);
        chk("cnt_same_r",  64'(s_rvalid & s_rready), 64'b010);
        step();
        m_rvalid = 1'b0;
        @(negedge clk);
        chk("cnt_one_more", 64'(s_arready), 64'b010);
        step();
        @(negedge clk);
        chk("cnt_full_again", 64'(s_arready), 64'b000);

        // Backpressure: slice holds, no more grants.
        do_reset(3'b000);
        m_arready = 1'b0;
        s_arvalid = 3'b001;
        s_arid[2:0]    = 3'd5;
        s_araddr[31:0] = 32'hCAFE_0040;
        @(negedge clk);
        chk("bp_gnt", 64'(s_arready), 64'b001);
        step();
        s_araddr[31:0] = 32'h0BAD_0000;
        s_arvalid      = 3'b111;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_vld",  64'(m_arvalid), 64'd1);
            chk("bp_addr", 64'(m_araddr),  64'hCAFE_0040);
            chk("bp_id",   64'(m_arid),    64'({2'd0, 3'd5}));
            chk("bp_nogt", 64'(s_arready), 64'b000);
            step();
        end
        m_arready = 1'b1;
        @(negedge clk);
        chk("bp_drain_gnt", 64'(s_arready), 64'b010);

        // R routing to SB.
        step();
        m_arready = 1'b0;
        s_arvalid = 3'b000;
        m_rvalid  = 1'b1;
        m_rid     = {2'd2, 3'd5};
        m_rdata   = 64'h0123_4567_89AB_CDEF;
        m_rresp   = 2'd2;
        m_rlast   = 1'b0;
        s_rready  = 3'b100;
        @(negedge clk);
        chk("r_svalid", 64'(s_rvalid), 64'b100);
        chk("r_sid",    64'(s_rid),    64'd5);
        chk("r_rready", 64'(m_rready), 64'd1);
        chk("r_rdata",  64'(s_rdata),  64'h0123_4567_89AB_CDEF);
        chk("r_rresp",  64'(s_rresp),  64'd2);
        step();
        s_rready = 3'b011;
        @(negedge clk);
        chk("r_rready_lo", 64'(m_rready), 64'd0);
        chk("r_svalid2",   64'(s_rvalid), 64'b100);

        // Illegal index 3.
        step();
        m_rid    = {2'd3, 3'd1};
        s_rready = 3'b000;
        @(negedge clk);
        chk("bad_rready", 64'(m_rready), 64'd1);
        chk("bad_svalid", 64'(s_rvalid), 64'b000);
        step();
        m_rvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bad_sticky", 64'(rid_err), 64'd1);
            step();
        end
        rst_l = 1'b0;
        #2;
        chk("bad_clr_rst", 64'(rid_err), 64'd0);
        step();
        rst_l = 1'b1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
